seven_seg_scan_ctrl: RTL
========================

# seven_seg_scan_ctrl

Scan controller for the four-digit seven-segment display path. It owns the select line of the 2:1 source mux in front of the display and switches sources only at frame boundaries, so a displayed frame never mixes two sources. It snapshots the selected 16-bit value and time-multiplexes it one nibble per digit to the hex decoder. It also drives the active-low digit enables.

## Interface
- REFRESH_DIV, 100000: CLK cycles per digit slot (1 kHz/digit at 100 MHz); legal range 2..2^20.
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SRC_REQ  in  1  requested display source (0 = mux IN0, 1 = mux IN1); sampled only at frame end.
- MUX_SEL  out  1  drives the 2:1 source mux select; registered.
- DATA_IN  in  16  mux OUT (selected value), combinational from MUX_SEL.
- DOT_IN  in  4  decimal-point requests, bit n = digit n.
- SEG_SEL  out  4  digit enables, active-low, one-hot-low or all-high (blank).
- HEX_OUT  out  4  nibble for the active digit, to the hex-to-segment decoder.
- DOT_OUT  out  1  decimal point for the active digit, active-high.
- FRAME_DONE  out  1  one-cycle pulse; a new frame is loading this cycle.

## Operation
- FSM, two states: LOAD, SCAN. Reset enters LOAD.
- LOAD (exactly 1 cycle): SEG_SEL = 4'b1111 (blank); at the clock edge, snap_data <= DATA_IN, snap_dot <= DOT_IN, prescaler <= 0, digit <= 0; next state SCAN.
- SCAN: prescaler counts 0..REFRESH_DIV-1; tick = (prescaler == REFRESH_DIV-1); prescaler wraps to 0 on tick.
- On tick with digit < 3: digit <= digit+1.
- On tick with digit == 3: MUX_SEL <= SRC_REQ, FRAME_DONE <= 1, next state LOAD.
- In SCAN: SEG_SEL[digit] = 0, others 1; HEX_OUT = snap_data[4*digit+3 : 4*digit]; DOT_OUT = snap_dot[digit].
- SEG_SEL/HEX_OUT/DOT_OUT are decoded only from registered state (no input-to-output combinational path).
- Because MUX_SEL changes on the edge entering LOAD, DATA_IN has a full cycle to settle through the mux before it is snapshotted.
- SRC_REQ and DATA_IN changes mid-frame have no visible effect until the next LOAD.
- Reset values: MUX_SEL 0, SEG_SEL 4'b1111, HEX_OUT 0, DOT_OUT 0, FRAME_DONE 0, snap_data 0, snap_dot 0, digit 0, prescaler 0.
- RESET asserted mid-frame: all of the above apply immediately (asynchronously), and the display blanks. After release, the first cycle is LOAD.

## Timing
- Frame length = 1 + 4*REFRESH_DIV cycles; each digit is lit for exactly REFRESH_DIV cycles.
- FRAME_DONE is high exactly during the LOAD cycle, once per frame. It is also not asserted in the first LOAD after reset.
- Source-switch latency: the new SRC_REQ becomes visible on MUX_SEL at most one frame plus 1 cycle after the request.
- Snapshot-to-display latency: 1 cycle (LOAD edge → digit 0 lit).

## Configuration
- SEG_LEADING_ZERO_BLANK_EN defined: in SCAN, digit n (n = 3..1) is blanked (SEG_SEL all 1, DOT_OUT 0) when snap_data nibbles n..3 are all zero and snap_dot bits n..3 are all zero. Digit 0 is never blanked. Slot timing is unchanged.
- Not defined: all four digits are always driven in SCAN.

## Test plan
- Reset, REFRESH_DIV=4, DATA_IN=16'h1234, DOT_IN=0 → cycle 0 blank (LOAD); cycles 1-4 SEG_SEL=1110/HEX 4; 5-8 1101/3; 9-12 1011/2; 13-16 0111/1; cycle 17 LOAD with FRAME_DONE=1.
- SRC_REQ 0→1 at cycle 6 → MUX_SEL stays 0 until the edge at end of cycle 16, is 1 in cycle 17, and the snapshot taken at cycle 17 shows the IN1 value from cycle 18.
- DATA_IN changed to 16'hABCD at cycle 8 → frame still shows 4,3,2,1; the next frame shows D,C,B,A.
- DOT_IN=4'b0100 → DOT_OUT=1 only while SEG_SEL=1011.
- RESET pulsed at cycle 10 mid-frame → outputs immediately return to reset values; after release, LOAD then digit 0 is lit for 4 cycles, and FRAME_DONE stays 0 in that LOAD.
- SEG_LEADING_ZERO_BLANK_EN, DATA_IN=16'h0050 → digits 3 and 2 blank, digits 1 (5) and 0 (0) lit; DATA_IN=0 → only digit 0 lit showing 0.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: frame-aligned source select, snapshot, digit multiplexing.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits (3..1).
module seven_seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SRC_REQ,
  output logic        MUX_SEL,
  input  logic [15:0] DATA_IN,
  input  logic [3:0]  DOT_IN,
  output logic [3:0]  SEG_SEL,
  output logic [3:0]  HEX_OUT,
  output logic        DOT_OUT,
  output logic        FRAME_DONE
);

  localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [1:0]    digit_q, digit_d;
  logic [15:0]   snap_data_q, snap_data_d;
  logic [3:0]    snap_dot_q, snap_dot_d;
  logic          mux_sel_q, mux_sel_d;
  logic          frame_done_q, frame_done_d;
  logic [3:0]    seg_sel_q, seg_sel_d;
  logic [3:0]    hex_out_q, hex_out_d;
  logic          dot_out_q, dot_out_d;
  logic          tick_c;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [3:0]    nz_c;
`endif

  assign MUX_SEL    = mux_sel_q;
  assign FRAME_DONE = frame_done_q;
  assign SEG_SEL    = seg_sel_q;
  assign HEX_OUT    = hex_out_q;
  assign DOT_OUT    = dot_out_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_LOAD;
      prescaler_q  <= '0;
      digit_q      <= 2'd0;
      snap_data_q  <= 16'h0000;
      snap_dot_q   <= 4'h0;
      mux_sel_q    <= 1'b0;
      frame_done_q <= 1'b0;
      seg_sel_q    <= 4'b1111;
      hex_out_q    <= 4'h0;
      dot_out_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prescaler_q  <= prescaler_d;
      digit_q      <= digit_d;
      snap_data_q  <= snap_data_d;
      snap_dot_q   <= snap_dot_d;
      mux_sel_q    <= mux_sel_d;
      frame_done_q <= frame_done_d;
      seg_sel_q    <= seg_sel_d;
      hex_out_q    <= hex_out_d;
      dot_out_q    <= dot_out_d;
    end
  end

  // Next state, then display outputs decoded from the next registered state so they land in step with it.
  always_comb begin
    state_d      = state_q;
    prescaler_d  = prescaler_q;
    digit_d      = digit_q;
    snap_data_d  = snap_data_q;
    snap_dot_d   = snap_dot_q;
    mux_sel_d    = mux_sel_q;
    frame_done_d = 1'b0;
    seg_sel_d    = 4'b1111;
    hex_out_d    = 4'h0;
    dot_out_d    = 1'b0;
    tick_c       = (state_q == ST_SCAN) && (prescaler_q == PRE_LAST);

    case (state_q)
      ST_LOAD: begin
        snap_data_d = DATA_IN;
        snap_dot_d  = DOT_IN;
        prescaler_d = '0;
        digit_d     = 2'd0;
        state_d     = ST_SCAN;
      end
      default: begin
        prescaler_d = tick_c ? '0 : prescaler_q + PW'(1);
        if (tick_c) begin
          if (digit_q == 2'd3) begin
            mux_sel_d    = SRC_REQ;
            frame_done_d = 1'b1;
            state_d      = ST_LOAD;
          end else begin
            digit_d = digit_q + 2'd1;
          end
        end
      end
    endcase

    if (state_d == ST_SCAN) begin
      seg_sel_d[digit_d] = 1'b0;
      hex_out_d          = snap_data_d[{digit_d, 2'b00} +: 4];
      dot_out_d          = snap_dot_d[digit_d];
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every more-significant digit carry neither a nibble nor a dot.
    for (int i = 0; i < 4; i++) begin
      nz_c[i] = (|snap_data_d[4*i +: 4]) | snap_dot_d[i];
    end
    if ((state_d == ST_SCAN) && (digit_d != 2'd0) && ((nz_c >> digit_d) == 4'd0)) begin
      seg_sel_d = 4'b1111;
      dot_out_d = 1'b0;
    end
`endif
  end

endmodule
